pu_share_arbiter: RTL and testbench

- Shares one 4-operand processing unit (PU: registered operand stage, adder tree, registered result stage; 2-cycle latency, one new operand set per cycle) among NREQ requesters.
- Round-robin grants, at most one issue per cycle.
- Tracks in-flight jobs with a tag pipeline matched to the PU latency, and returns each result to a per-requester holding register with valid/ack.
- Sits between the requesting engines and a single PU instance outside this block.

---
 rtl/pu_share_arbiter_pkg.sv | 29 ++
 rtl/pu_rr_picker.sv | 37 +++
 rtl/pu_share_arbiter.sv | 149 ++++++++++++++
 tb/tb_pu_share_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pu_share_arbiter_pkg.sv
// Shared definitions for the processing-unit share arbiter: default sizes,
// the in-flight tag record and the operand slice helper.
package pu_share_arbiter_pkg;

    localparam int XLEN_DFLT = 5;   // operand/result width, must match the PU
    localparam int NREQ_DFLT = 4;   // number of requesters (2..8)
    localparam int LAT_DFLT  = 2;   // PU latency, operands to result

    // Width of a requester index; never below one bit
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Default index width and the tag id width, sized for the largest NREQ (8)
    localparam int ID_W     = id_w(NREQ_DFLT);
    localparam int TAG_ID_W = id_w(8);

    // One in-flight job marker travelling alongside the PU pipeline
    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    // Operand k of requester i lives at slice index 4*i+k of req_ops
    function automatic int op_idx(input int i, input int k);
        return 4 * i + k;
    endfunction

endpackage

// File: rtl/pu_rr_picker.sv
// Combinational round-robin picker: first eligible index at or after ptr,
// wrapping modulo NREQ.
module pu_rr_picker #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] elig,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            gnt_valid
);

    // Scan from ptr upward with wrap; the first hit wins
    always_comb begin
        int             j;
        logic [IDW-1:0] jj;
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        j         = 0;
        jj        = '0;
        for (int off = 0; off < NREQ; off++) begin
            j = int'(ptr) + off;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            jj = IDW'(j);
            if (!gnt_valid && elig[jj]) begin
                gnt_valid = 1'b1;
                gnt[jj]   = 1'b1;
                gnt_idx   = jj;
            end
        end
    end

endmodule

// File: rtl/pu_share_arbiter.sv
// Shares one fixed-latency 4-operand PU among NREQ requesters: round-robin
// issue, a tag pipeline matched to the PU latency, and per-requester result
// holding registers released by res_ack.
//
// Handshakes: a requester holds req and its operands until it sees gnt (the
// grant cycle is the transfer). A result is offered with res_valid and stays
// until res_ack is sampled high while res_valid is high; the requester may not
// be granted again until the cycle after that acknowledge.
module pu_share_arbiter
    import pu_share_arbiter_pkg::*;
#(
    parameter int XLEN = XLEN_DFLT,
    parameter int NREQ = NREQ_DFLT,
    parameter int LAT  = LAT_DFLT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*4*XLEN-1:0] req_ops,
    output logic [NREQ-1:0]        gnt,
    output logic [XLEN-1:0]        pu_num1,
    output logic [XLEN-1:0]        pu_num2,
    output logic [XLEN-1:0]        pu_num3,
    output logic [XLEN-1:0]        pu_num4,
    input  logic [XLEN-1:0]        pu_result,
    output logic [NREQ-1:0]        res_valid,
    output logic [NREQ*XLEN-1:0]   res_data,
    input  logic [NREQ-1:0]        res_ack
);

    localparam int IDW = id_w(NREQ);

    logic [NREQ-1:0]      busy_q, busy_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    tag_t                 tag_q [LAT];
    tag_t                 tag_d [LAT];
    logic [NREQ-1:0]      res_valid_q, res_valid_d;
    logic [NREQ*XLEN-1:0] res_data_q, res_data_d;

    logic [NREQ-1:0]      elig;
    logic [NREQ-1:0]      pick_gnt;
    logic [IDW-1:0]       pick_idx;
    logic                 pick_valid;
    logic                 grant_en;
    logic [NREQ-1:0]      cap_hit;
    logic [NREQ-1:0]      ack_hit;

    // A requester with a job in flight or a result still held is not eligible
    assign elig     = req & ~busy_q;
    assign grant_en = pick_valid & ~rst;
    assign gnt      = rst ? '0 : pick_gnt;

    pu_rr_picker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_picker (
        .elig      (elig),
        .ptr       (ptr_q),
        .gnt       (pick_gnt),
        .gnt_idx   (pick_idx),
        .gnt_valid (pick_valid)
    );

    // Steer the granted requester's operands to the PU; zeros when idle
    always_comb begin
        pu_num1 = '0;
        pu_num2 = '0;
        pu_num3 = '0;
        pu_num4 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                pu_num1 = req_ops[op_idx(i, 0)*XLEN +: XLEN];
                pu_num2 = req_ops[op_idx(i, 1)*XLEN +: XLEN];
                pu_num3 = req_ops[op_idx(i, 2)*XLEN +: XLEN];
                pu_num4 = req_ops[op_idx(i, 3)*XLEN +: XLEN];
            end
        end
    end

    // Pointer moves just past the winner; holds when nothing is granted
    always_comb begin
        ptr_d = ptr_q;
        if (grant_en) begin
            if (int'(pick_idx) == NREQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = pick_idx + IDW'(1);
            end
        end
    end

    // Tag pipeline: stage 0 records this cycle's issue, later stages shift
    always_comb begin
        tag_d[0].valid = grant_en;
        tag_d[0].id    = TAG_ID_W'(pick_idx);
        for (int s = 1; s < LAT; s++) begin
            tag_d[s] = tag_q[s-1];
        end
    end

    // Capture results from the last tag stage, release on ack, track busy
    always_comb begin
        cap_hit     = '0;
        ack_hit     = res_ack & res_valid_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        busy_d      = busy_q;
        for (int i = 0; i < NREQ; i++) begin
            cap_hit[i] = tag_q[LAT-1].valid && (tag_q[LAT-1].id == TAG_ID_W'(i));
            if (cap_hit[i]) begin
                res_valid_d[i]                = 1'b1;
                res_data_d[i*XLEN +: XLEN]    = pu_result;
            end
            if (ack_hit[i]) begin
                res_valid_d[i] = 1'b0;
                busy_d[i]      = 1'b0;
            end
            if (grant_en && pick_gnt[i]) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    // State registers; reset drops every in-flight tag and held result
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            ptr_q       <= '0;
            res_valid_q <= '0;
            res_data_q  <= '0;
            for (int s = 0; s < LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            busy_q      <= busy_d;
            ptr_q       <= ptr_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            tag_q       <= tag_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

    // busy blocks a re-grant, so a capture can never meet an ack of the same slot
    cap_ack_exclusive: assert property (@(posedge clk) disable iff (rst) (cap_hit & ack_hit) == '0);

endmodule

// File: tb/tb_pu_share_arbiter.sv
// Directed bench for pu_share_arbiter with a stub PU (result = num1 ^ num3,
// LAT register stages) and an in-order result scoreboard.
module tb_pu_share_arbiter;

    localparam int XLEN = 5;
    localparam int NREQ = 4;
    localparam int LAT  = 2;
    localparam int EW   = 32 + 8 + XLEN;   // {arrival cycle, id, data}

    logic                   clk;
    logic                   rst;
    logic [NREQ-1:0]        req;
    logic [NREQ*4*XLEN-1:0] req_ops;
    logic [NREQ-1:0]        gnt;
    logic [XLEN-1:0]        pu_num1, pu_num2, pu_num3, pu_num4;
    logic [XLEN-1:0]        pu_result;
    logic [NREQ-1:0]        res_valid;
    logic [NREQ*XLEN-1:0]   res_data;
    logic [NREQ-1:0]        res_ack;

    logic [XLEN-1:0]        ops [NREQ][4];
    logic [XLEN-1:0]        pu_s [LAT];
    logic [EW-1:0]          exp_q [$];
    logic [NREQ-1:0]        rv_prev;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_grants;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    pu_share_arbiter #(.XLEN(XLEN), .NREQ(NREQ), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_ops   (req_ops),
        .gnt       (gnt),
        .pu_num1   (pu_num1),
        .pu_num2   (pu_num2),
        .pu_num3   (pu_num3),
        .pu_num4   (pu_num4),
        .pu_result (pu_result),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ack   (res_ack)
    );

    // Stub PU: LAT register stages carrying num1 ^ num3
    always @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < LAT; s++) pu_s[s] <= '0;
        end else begin
            pu_s[0] <= pu_num1 ^ pu_num3;
            for (int s = 1; s < LAT; s++) pu_s[s] <= pu_s[s-1];
        end
    end
    assign pu_result = pu_s[LAT-1];

    always_comb begin
        req_ops = '0;
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 4; k++)
                req_ops[(4*i+k)*XLEN +: XLEN] = ops[i][k];
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_ops(input int i, input int a, input int b, input int c, input int d);
        ops[i][0] = XLEN'(a);
        ops[i][1] = XLEN'(b);
        ops[i][2] = XLEN'(c);
        ops[i][3] = XLEN'(d);
    endtask

    // Leaves the bench at the start of cycle 1 with the DUT freshly reset
    task automatic do_reset();
        rst     = 1'b1;
        req     = '0;
        res_ack = '0;
        exp_q.delete();
        tick();
        rst = 1'b0;
        cyc = 1;
    endtask

    function automatic logic [XLEN-1:0] rd(input int i);
        return res_data[i*XLEN +: XLEN];
    endfunction

    task automatic expect_cycle(input string tag, input logic [NREQ-1:0] g, input logic [NREQ-1:0] rv);
        @(negedge clk);
        chk({tag, "_gnt"}, gnt, g);
        chk({tag, "_rv"}, res_valid, rv);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst) begin
            rv_prev = res_valid;
        end else begin
            if (gnt != '0) begin
                int idx;
                idx = 0;
                for (int i = 0; i < NREQ; i++) if (gnt[i]) idx = i;
                chk("gnt_onehot", 64'($onehot(gnt)), 1);
                chk("mon_num1", pu_num1, ops[idx][0]);
                chk("mon_num2", pu_num2, ops[idx][1]);
                chk("mon_num3", pu_num3, ops[idx][2]);
                chk("mon_num4", pu_num4, ops[idx][3]);
                exp_q.push_back({32'(cyc + LAT + 1), 8'(idx), ops[idx][0] ^ ops[idx][2]});
            end else begin
                chk("mon_idle_nums", {pu_num1, pu_num2, pu_num3, pu_num4}, '0);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (res_valid[i] && !rv_prev[i]) begin
                    chk("res_expected_any", 64'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        logic [EW-1:0] e;
                        e = exp_q.pop_front();
                        chk("res_id", i, e[XLEN +: 8]);
                        chk("res_cycle", cyc, e[XLEN+8 +: 32]);
                        chk("res_data", rd(i), e[XLEN-1:0]);
                    end
                end
            end
            rv_prev = res_valid;
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst     = 1'b1;
        req     = '0;
        res_ack = '0;
        for (int i = 0; i < NREQ; i++) set_ops(i, 0, 0, 0, 0);

        // 1. reset holds everything quiet even with random requests
        for (int c = 0; c < 3; c++) begin
            req = NREQ'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++)
                set_ops(i, $urandom_range(0, 31), $urandom_range(0, 31),
                        $urandom_range(0, 31), $urandom_range(0, 31));
            @(negedge clk);
            chk("rst_gnt", gnt, '0);
            chk("rst_rv", res_valid, '0);
            chk("rst_data", res_data, '0);
            chk("rst_nums", {pu_num1, pu_num2, pu_num3, pu_num4}, '0);
            tick();
        end
        rst = 1'b0;
        req = '0;
        cyc = 1;

        // 2. single job, result held until ack, ignored ack, earliest re-grant
        set_ops(0, 7, 1, 3, 9);
        req = 4'b0001;
        @(negedge clk);
        chk("single_gnt", gnt, 4'b0001);
        chk("single_num1", pu_num1, 7);
        chk("single_num3", pu_num3, 3);
        tick();
        req = '0;
        expect_cycle("single_c2", 4'b0000, 4'b0000);
        tick();
        expect_cycle("single_c3", 4'b0000, 4'b0000);
        tick();
        expect_cycle("single_c4", 4'b0000, 4'b0001);
        chk("single_data_c4", rd(0), 4);
        tick();
        expect_cycle("single_hold5", 4'b0000, 4'b0001);
        tick();
        expect_cycle("single_hold6", 4'b0000, 4'b0001);
        chk("single_data_c6", rd(0), 4);
        tick();
        res_ack = 4'b0001;
        expect_cycle("single_ack7", 4'b0000, 4'b0001);
        tick();
        res_ack = 4'b0010;   // no result held for requester 1
        req     = 4'b0001;
        expect_cycle("single_regrant8", 4'b0001, 4'b0000);
        chk("single_data_kept", rd(0), 4);
        tick();
        res_ack = '0;
        req     = '0;
        expect_cycle("single_ign_ack9", 4'b0000, 4'b0000);
        tick();

        // 3. all requesters at once, then 4. busy blocks re-grant until ack
        do_reset();
        for (int i = 0; i < NREQ; i++) set_ops(i, 5*i + 2, 5*i + 5, 5*i + 8, 5*i + 11);
        req = 4'b1111;
        for (int c = 1; c <= 9; c++) begin
            logic [NREQ-1:0] eg, erv;
            eg  = (c <= 4) ? NREQ'(1 << (c - 1)) : '0;
            erv = (c < 4) ? '0 : (c >= 7) ? 4'b1111 : NREQ'((1 << (c - 3)) - 1);
            expect_cycle("all4", eg, erv);
            tick();
        end
        for (int i = 0; i < NREQ; i++) chk("all4_data", rd(i), ops[i][0] ^ ops[i][2]);
        res_ack = 4'b0001;
        expect_cycle("busy_ack10", 4'b0000, 4'b1111);
        tick();
        res_ack = '0;
        expect_cycle("busy_regrant11", 4'b0001, 4'b1110);
        tick();

        // 5. fairness between two always-requesting engines
        do_reset();
        req      = 4'b0101;
        n_grants = 0;
        for (int c = 1; c <= 24; c++) begin
            logic [NREQ-1:0] eg;
            res_ack = res_valid & 4'b0101;
            eg = (c % 4 == 1) ? 4'b0001 : (c % 4 == 2) ? 4'b0100 : 4'b0000;
            @(negedge clk);
            chk("fair_gnt", gnt, eg);
            if (gnt != '0) n_grants++;
            tick();
        end
        chk("fair_count", n_grants, 12);

        // 6. reset while a job is in flight
        do_reset();
        set_ops(1, 6, 0, 10, 0);
        set_ops(3, 21, 4, 2, 8);
        req = 4'b0010;
        expect_cycle("midrst_gnt", 4'b0010, 4'b0000);
        tick();
        rst = 1'b1;
        req = '0;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_gnt_in_rst", gnt, '0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            expect_cycle("midrst_quiet", 4'b0000, 4'b0000);
            tick();
        end
        req = 4'b1010;
        expect_cycle("midrst_ptr0", 4'b0010, 4'b0000);
        tick();
        expect_cycle("midrst_next", 4'b1000, 4'b0000);
        tick();
        req = '0;
        for (int c = 0; c < 6; c++) begin
            res_ack = res_valid;
            @(negedge clk);
            tick();
        end
        chk("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
